pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Owns the F/D and D/X pipeline latches and acts on the hazard stall request from the interlock detector. It also acts on multdiv busy status and branch flushes.
- It freezes the PC and the F/D latch, injects NOP bubbles into D/X, and squashes on flush.
- It runs the multicycle mul/div handshake: start pulse, freeze until ready, timeout.
- It sits between fetch and execute; the X/M latch is controlled through xm_advance.

Parameters:
NOP, 32'h0000_0000, bubble instruction injected into latches
MD_TIMEOUT, 40, max MD_WAIT cycles before forced release
CNT_W, 32, width of bubble performance counter

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
load_use_stall  in  1  interlock stall request; combinational from current fd_insn/dx_insn
branch_flush  in  1  taken branch/jump resolved in X; squash F/D and D/X
fetch_pc  in  32  PC of fetched instruction
fetch_insn  in  32  fetched instruction
md_ready  in  1  multdiv result valid (single-cycle pulse)
pc_we  out  1  PC register write enable
fd_pc  out  32  F/D latched PC
fd_insn  out  32  F/D latched instruction
dx_pc  out  32  D/X latched PC
dx_insn  out  32  D/X latched instruction
xm_advance  out  1  X/M latch may capture D/X results this cycle
md_start  out  1  one-cycle start pulse to multdiv
md_is_div  out  1  valid with md_start: 1=div, 0=mul
md_timeout  out  1  one-cycle pulse on forced MD release
bubble_count  out  CNT_W  number of load-use bubbles inserted, wraps

Behaviour:
- Instruction fields: opcode [31:27], ALU op [6:2].
- dx_is_md = (dx_insn[31:27]==5'b00000) && (dx_insn[6:2]==5'b00110 (mul) or 5'b00111 (div)).
- Reset (async, any time): fd_*, dx_* = NOP/0; state=IDLE; md cycle counter=0; bubble_count=0.
- Reset outputs: pc_we=1, xm_advance=1, md_start=0, md_timeout=0.
- Reset mid-MD_WAIT abandons the operation; a later md_ready is ignored in IDLE.
- States: IDLE, MD_WAIT. All outputs except the registered latches are combinational from state and inputs.
- IDLE with dx_is_md=0, priority order:
  - branch_flush: fd<=NOP, dx<=NOP, pc_we=1. Overrides a simultaneous stall, and the stall is not counted.
  - else load_use_stall: fd holds, dx<=NOP (dx_pc<=0), pc_we=0, bubble_count+=1.
  - else: fd<=fetch, dx<=fd, pc_we=1.
  - xm_advance=1 in all three cases.
- IDLE with dx_is_md=1:
  - md_start=1 and md_is_div=dx_insn[2].
  - Freeze: pc_we=0, fd/dx hold, xm_advance=0.
  - Counter<=0; next state MD_WAIT.
  - Flush and stall inputs are ignored this cycle.
- MD_WAIT without md_ready:
  - Freeze as above; md_start=0; counter+=1.
  - branch_flush is ignored, since X holds mul/div and no branch can resolve.
- MD_WAIT with md_ready:
  - xm_advance=1, and the pipeline advances per the IDLE priority rules above (flush/stall/normal).
  - Next state IDLE.
  - dx is overwritten on the same edge, so there is no restart. A back-to-back mul/div restarts in the following cycle.
- Timeout: MD_WAIT with counter==MD_TIMEOUT-1 and no md_ready:
  - md_timeout=1; release exactly as if md_ready; next state IDLE.
  - A late md_ready in IDLE is ignored.
- md_start never asserts twice for the same dx_insn occupancy.
- Latency:
  - Normal advance is 1 cycle per latch.
  - A load-use stall costs exactly 1 bubble.
  - A mul/div holds D/X for 1 + N cycles, where md_ready arrives N cycles after md_start, 1 <= N <= MD_TIMEOUT.
- bubble_count wraps modulo 2^CNT_W.

Decomposition:
- Shared package: the NOP constant, opcode/ALU op field positions, OP_RTYPE=5'b00000, ALU_MUL=5'b00110, ALU_DIV=5'b00111, and the state encoding.
- One natural sub-module, pipe_latch: a 64-bit PC+insn register with async reset, hold, and bubble-load controls.
- pipe_latch is instantiated for F/D and for D/X.

Test Plan:
- Load-use: fetch 32'h40C20000 (lw $3,0($1)) then 32'h01062000 (add $4,$3,$2); assert load_use_stall for 1 cycle while add is in F/D and lw in D/X -> pc_we=0, fd_insn stays 32'h01062000, dx_insn=0 next cycle, bubble_count=1.
- Mul handshake: 32'h01422018 (mul $5,$1,$2) reaches D/X -> md_start=1, md_is_div=0 for 1 cycle; md_ready 5 cycles later -> pipeline frozen 6 cycles total, xm_advance=1 only in the ready cycle, state back to IDLE.
- Flush vs stall: branch_flush and load_use_stall both high in IDLE -> fd_insn=0, dx_insn=0, pc_we=1, bubble_count unchanged.
- Timeout: mul enters D/X, md_ready never asserts -> md_timeout pulses exactly on cycle 40 of MD_WAIT, then release; a later md_ready causes no effect.
- Back-to-back div: div followed by div, each md_ready after 3 cycles -> two distinct md_start pulses with md_is_div=1, separated by exactly 1 advance cycle.
- Async reset asserted mid-MD_WAIT -> all latches 0 immediately (no clock edge), md_start=0; after release the pipeline fetches normally.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants, instruction field positions and FSM encoding for the stall controller.
package pipeline_stall_ctrl_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    // Instruction field positions
    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 27;
    localparam int unsigned ALU_HI  = 6;
    localparam int unsigned ALU_LO  = 2;
    localparam int unsigned DIV_BIT = 2;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // True when the instruction is an R-type mul or div.
    function automatic logic is_muldiv(input logic [31:0] insn);
        return (insn[OPC_HI:OPC_LO] == OP_RTYPE) &&
               ((insn[ALU_HI:ALU_LO] == ALU_MUL) || (insn[ALU_HI:ALU_LO] == ALU_DIV));
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_latch.sv
// PC + instruction pipeline register with hold and bubble-load controls.
module pipe_latch
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSN
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_insn,
    output logic [31:0] o_pc,
    output logic [31:0] o_insn
);

    logic [31:0] r_pc;
    logic [31:0] r_insn;

    // Bubble wins over hold; otherwise capture unless held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc   <= 32'h0;
            r_insn <= NOP;
        end else if (i_bubble) begin
            r_pc   <= 32'h0;
            r_insn <= NOP;
        end else if (!i_hold) begin
            r_pc   <= i_pc;
            r_insn <= i_insn;
        end
    end

    assign o_pc   = r_pc;
    assign o_insn = r_insn;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// F/D and D/X latch control: load-use bubbles, branch squash and the mul/div wait handshake.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP        = NOP_INSN,
    parameter int unsigned MD_TIMEOUT = 40,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load_use_stall,
    input  logic             i_branch_flush,
    input  logic [31:0]      i_fetch_pc,
    input  logic [31:0]      i_fetch_insn,
    input  logic             i_md_ready,
    output logic             o_pc_we,
    output logic [31:0]      o_fd_pc,
    output logic [31:0]      o_fd_insn,
    output logic [31:0]      o_dx_pc,
    output logic [31:0]      o_dx_insn,
    output logic             o_xm_advance,
    output logic             o_md_start,
    output logic             o_md_is_div,
    output logic             o_md_timeout,
    output logic [CNT_W-1:0] o_bubble_count
);

    localparam int unsigned MD_CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [MD_CNT_W-1:0] r_md_cnt;
    logic [MD_CNT_W-1:0] w_md_cnt_next;
    logic [CNT_W-1:0]    r_bubble_count;

    logic w_dx_is_md;
    logic w_advance;
    logic w_bubble_inc;
    logic w_fd_hold;
    logic w_fd_bubble;
    logic w_dx_hold;
    logic w_dx_bubble;

    assign w_dx_is_md = is_muldiv(o_dx_insn);

    pipe_latch #(
        .NOP (NOP)
    ) u_fd (
        .i_clk    (i_clock),
        .i_rst    (i_reset),
        .i_hold   (w_fd_hold),
        .i_bubble (w_fd_bubble),
        .i_pc     (i_fetch_pc),
        .i_insn   (i_fetch_insn),
        .o_pc     (o_fd_pc),
        .o_insn   (o_fd_insn)
    );

    pipe_latch #(
        .NOP (NOP)
    ) u_dx (
        .i_clk    (i_clock),
        .i_rst    (i_reset),
        .i_hold   (w_dx_hold),
        .i_bubble (w_dx_bubble),
        .i_pc     (o_fd_pc),
        .i_insn   (o_fd_insn),
        .o_pc     (o_dx_pc),
        .o_insn   (o_dx_insn)
    );

    // Next state, latch controls and handshake outputs.
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        w_advance     = 1'b0;
        w_bubble_inc  = 1'b0;
        w_fd_hold     = 1'b0;
        w_fd_bubble   = 1'b0;
        w_dx_hold     = 1'b0;
        w_dx_bubble   = 1'b0;
        o_pc_we       = 1'b1;
        o_xm_advance  = 1'b1;
        o_md_start    = 1'b0;
        o_md_is_div   = 1'b0;
        o_md_timeout  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_dx_is_md) begin
                    // Kick off mul/div and freeze; flush/stall cannot apply with X busy.
                    o_md_start    = 1'b1;
                    o_md_is_div   = o_dx_insn[DIV_BIT];
                    o_pc_we       = 1'b0;
                    o_xm_advance  = 1'b0;
                    w_fd_hold     = 1'b1;
                    w_dx_hold     = 1'b1;
                    w_md_cnt_next = '0;
                    w_state_next  = MD_WAIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            MD_WAIT: begin
                if (i_md_ready || (r_md_cnt == MD_LAST)) begin
                    o_md_timeout = !i_md_ready;
                    w_advance    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    o_pc_we       = 1'b0;
                    o_xm_advance  = 1'b0;
                    w_fd_hold     = 1'b1;
                    w_dx_hold     = 1'b1;
                    w_md_cnt_next = r_md_cnt + MD_CNT_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Advance rules shared by IDLE and mul/div release: flush > stall > normal.
        if (w_advance) begin
            if (i_branch_flush) begin
                w_fd_bubble = 1'b1;
                w_dx_bubble = 1'b1;
            end else if (i_load_use_stall) begin
                o_pc_we      = 1'b0;
                w_fd_hold    = 1'b1;
                w_dx_bubble  = 1'b1;
                w_bubble_inc = 1'b1;
            end
        end
    end

    // FSM state, mul/div wait counter and bubble performance counter.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_md_cnt       <= '0;
            r_bubble_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
            if (w_bubble_inc) begin
                r_bubble_count <= r_bubble_count + CNT_W'(1);
            end
        end
    end

    assign o_bubble_count = r_bubble_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a monitor pops and checks them.
module tb_pipeline_stall_ctrl;

    localparam logic [31:0] LW  = 32'h40C2_0000;
    localparam logic [31:0] ADD = 32'h0106_2000;
    localparam logic [31:0] MUL = 32'h0142_2018;
    localparam logic [31:0] DIV = 32'h0142_201C;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] fpc   = 32'h0;
    logic [31:0] finsn = 32'h0;

    logic        pc_we, xm_advance, md_start, md_is_div, md_timeout;
    logic [31:0] fd_pc, fd_insn, dx_pc, dx_insn, bubble_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        pc_we;
        logic        xm;
        logic        mds;
        logic        mdd;
        logic        mdt;
        logic [31:0] fd_pc;
        logic [31:0] fd_insn;
        logic [31:0] dx_pc;
        logic [31:0] dx_insn;
        logic [31:0] bc;
    } exp_t;

    exp_t  sb[$];
    string nq[$];

    pipeline_stall_ctrl #(
        .NOP        (32'h0),
        .MD_TIMEOUT (40),
        .CNT_W      (32)
    ) dut (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_load_use_stall (stall),
        .i_branch_flush   (flush),
        .i_fetch_pc       (fpc),
        .i_fetch_insn     (finsn),
        .i_md_ready       (ready),
        .o_pc_we          (pc_we),
        .o_fd_pc          (fd_pc),
        .o_fd_insn        (fd_insn),
        .o_dx_pc          (dx_pc),
        .o_dx_insn        (dx_insn),
        .o_xm_advance     (xm_advance),
        .o_md_start       (md_start),
        .o_md_is_div      (md_is_div),
        .o_md_timeout     (md_timeout),
        .o_bubble_count   (bubble_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] fi(input int k);
        return 32'h0800_0000 + (32'(k) << 8);
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Queue this cycle's expected outputs, then move just past the next rising edge.
    task automatic cyc(input string nm, input logic pw, input logic xm, input logic mds,
                       input logic mdd, input logic mdt, input logic [31:0] fdp,
                       input logic [31:0] fdi, input logic [31:0] dxp, input logic [31:0] dxi,
                       input logic [31:0] bc);
        exp_t e;
        e.pc_we = pw; e.xm = xm; e.mds = mds; e.mdd = mdd; e.mdt = mdt;
        e.fd_pc = fdp; e.fd_insn = fdi; e.dx_pc = dxp; e.dx_insn = dxi; e.bc = bc;
        sb.push_back(e);
        nq.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    // Monitor: every falling edge, check the DUT against the oldest expectation.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                nm = nq.pop_front();
                cmp(nm, "pc_we", 32'(pc_we), 32'(e.pc_we));
                cmp(nm, "xm_advance", 32'(xm_advance), 32'(e.xm));
                cmp(nm, "md_start", 32'(md_start), 32'(e.mds));
                if (e.mds) cmp(nm, "md_is_div", 32'(md_is_div), 32'(e.mdd));
                cmp(nm, "md_timeout", 32'(md_timeout), 32'(e.mdt));
                cmp(nm, "fd_pc", fd_pc, e.fd_pc);
                cmp(nm, "fd_insn", fd_insn, e.fd_insn);
                cmp(nm, "dx_pc", dx_pc, e.dx_pc);
                cmp(nm, "dx_insn", dx_insn, e.dx_insn);
                cmp(nm, "bubble_count", bubble_count, e.bc);
            end
        end
    end

    initial begin
        @(posedge clock);
        #1;
        cyc("reset", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Load-use bubble
        fpc = 32'h100; finsn = LW;
        cyc("lu_fill0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        fpc = 32'h104; finsn = ADD;
        cyc("lu_fill1", 1, 1, 0, 0, 0, 32'h100, LW, 0, 0, 0);
        fpc = 32'h108; finsn = fi(1); stall = 1'b1;
        cyc("lu_stall", 0, 1, 0, 0, 0, 32'h104, ADD, 32'h100, LW, 0);
        stall = 1'b0;
        cyc("lu_bubble", 1, 1, 0, 0, 0, 32'h104, ADD, 0, 0, 1);
        fpc = 32'h10C; finsn = fi(2);
        cyc("lu_resume", 1, 1, 0, 0, 0, 32'h108, fi(1), 32'h104, ADD, 1);

        // Flush beats stall, stall not counted
        fpc = 32'h110; finsn = fi(3); flush = 1'b1; stall = 1'b1;
        cyc("fl_both", 1, 1, 0, 0, 0, 32'h10C, fi(2), 32'h108, fi(1), 1);
        flush = 1'b0; stall = 1'b0; fpc = 32'h200; finsn = MUL;
        cyc("fl_squashed", 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Mul handshake, ready 5 cycles after start
        fpc = 32'h204; finsn = fi(4);
        cyc("mul_fill", 1, 1, 0, 0, 0, 32'h200, MUL, 0, 0, 1);
        fpc = 32'h208; finsn = fi(5);
        cyc("mul_start", 0, 0, 1, 0, 0, 32'h204, fi(4), 32'h200, MUL, 1);
        for (int i = 0; i < 4; i++)
            cyc("mul_wait", 0, 0, 0, 0, 0, 32'h204, fi(4), 32'h200, MUL, 1);
        ready = 1'b1;
        cyc("mul_ready", 1, 1, 0, 0, 0, 32'h204, fi(4), 32'h200, MUL, 1);
        ready = 1'b0; fpc = 32'h20C; finsn = DIV;
        cyc("mul_after", 1, 1, 0, 0, 0, 32'h208, fi(5), 32'h204, fi(4), 1);

        // Back-to-back div
        fpc = 32'h210; finsn = DIV;
        cyc("div_fill", 1, 1, 0, 0, 0, 32'h20C, DIV, 32'h208, fi(5), 1);
        fpc = 32'h214; finsn = fi(6);
        cyc("div1_start", 0, 0, 1, 1, 0, 32'h210, DIV, 32'h20C, DIV, 1);
        for (int i = 0; i < 2; i++)
            cyc("div1_wait", 0, 0, 0, 0, 0, 32'h210, DIV, 32'h20C, DIV, 1);
        ready = 1'b1;
        cyc("div1_ready", 1, 1, 0, 0, 0, 32'h210, DIV, 32'h20C, DIV, 1);
        ready = 1'b0; fpc = 32'h218; finsn = fi(7);
        cyc("div2_start", 0, 0, 1, 1, 0, 32'h214, fi(6), 32'h210, DIV, 1);
        for (int i = 0; i < 2; i++)
            cyc("div2_wait", 0, 0, 0, 0, 0, 32'h214, fi(6), 32'h210, DIV, 1);
        ready = 1'b1;
        cyc("div2_ready", 1, 1, 0, 0, 0, 32'h214, fi(6), 32'h210, DIV, 1);
        ready = 1'b0; fpc = 32'h21C; finsn = MUL;
        cyc("div_after", 1, 1, 0, 0, 0, 32'h218, fi(7), 32'h214, fi(6), 1);

        // Timeout on the 40th wait cycle; flush ignored while waiting
        fpc = 32'h220; finsn = fi(8);
        cyc("tmo_fill", 1, 1, 0, 0, 0, 32'h21C, MUL, 32'h218, fi(7), 1);
        fpc = 32'h224; finsn = fi(9);
        cyc("tmo_start", 0, 0, 1, 0, 0, 32'h220, fi(8), 32'h21C, MUL, 1);
        for (int i = 0; i < 39; i++) begin
            flush = (i == 10);
            cyc("tmo_wait", 0, 0, 0, 0, 0, 32'h220, fi(8), 32'h21C, MUL, 1);
        end
        flush = 1'b0;
        cyc("tmo_fire", 1, 1, 0, 0, 1, 32'h220, fi(8), 32'h21C, MUL, 1);
        ready = 1'b1; fpc = 32'h228; finsn = fi(10);
        cyc("tmo_late_rdy", 1, 1, 0, 0, 0, 32'h224, fi(9), 32'h220, fi(8), 1);

        // Async reset in the middle of a mul wait
        ready = 1'b0; fpc = 32'h22C; finsn = MUL;
        cyc("rst_fill0", 1, 1, 0, 0, 0, 32'h228, fi(10), 32'h224, fi(9), 1);
        fpc = 32'h230; finsn = fi(11);
        cyc("rst_fill1", 1, 1, 0, 0, 0, 32'h22C, MUL, 32'h228, fi(10), 1);
        cyc("rst_md_start", 0, 0, 1, 0, 0, 32'h230, fi(11), 32'h22C, MUL, 1);
        cyc("rst_md_wait", 0, 0, 0, 0, 0, 32'h230, fi(11), 32'h22C, MUL, 1);
        reset = 1'b1;
        #1;
        cmp("rst_async", "fd_insn", fd_insn, 32'h0);
        cmp("rst_async", "dx_insn", dx_insn, 32'h0);
        cmp("rst_async", "dx_pc", dx_pc, 32'h0);
        cmp("rst_async", "bubble_count", bubble_count, 32'h0);
        cyc("rst_held", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0; ready = 1'b1; fpc = 32'h300; finsn = fi(12);
        cyc("rst_after0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        ready = 1'b0; fpc = 32'h304; finsn = fi(13);
        cyc("rst_after1", 1, 1, 0, 0, 0, 32'h300, fi(12), 0, 0, 0);
        fpc = 32'h308; finsn = fi(14);
        cyc("rst_after2", 1, 1, 0, 0, 0, 32'h304, fi(13), 32'h300, fi(12), 0);

        // Let the monitor drain, bounded
        repeat (3) @(negedge clock);
        #1;
        cmp("drain", "pending", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
